// File: rtl/cnt_updown_ff_if.sv
// Control/data bundle for the structural up/down counter.
interface cnt_updown_ff_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             ld;
  logic             up;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (output en, ld, up, din, input q, tc);
  modport slave  (input en, ld, up, din, output q, tc);
endinterface

// File: rtl/cnt_updown_ff.sv
// Loadable up/down counter built only from library cells: one dff per bit,
// a ripple toggle chain for the arithmetic and gate-level reset/load muxing.

module dff (
  input  logic clk,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) q <= d;
endmodule

module inv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module cnt_updown_ff #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  cnt_updown_ff_if.slave bus
);
  logic             rst_n, ld_n, up_n;
  logic [WIDTH:0]   tgl;    // tgl[i]: bit i flips this edge; tgl[WIDTH]: whole word wraps
  logic [WIDTH-1:0] mtch, nxt, ld_v, cnt_v, mux, d, q;

  inv u_rst_n (.a(rst),    .y(rst_n));
  inv u_ld_n  (.a(bus.ld), .y(ld_n));
  inv u_up_n  (.a(bus.up), .y(up_n));

  assign tgl[0] = bus.en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // mtch[i] = (q[i] == up): all-ones when counting up, all-zeros when down
    xor2 u_mtch (.a(q[i]),      .b(up_n),       .y(mtch[i]));
    and2 u_tgl  (.a(tgl[i]),    .b(mtch[i]),    .y(tgl[i+1]));
    xor2 u_nxt  (.a(q[i]),      .b(tgl[i]),     .y(nxt[i]));
    and2 u_ldv  (.a(bus.ld),    .b(bus.din[i]), .y(ld_v[i]));
    and2 u_cntv (.a(ld_n),      .b(nxt[i]),     .y(cnt_v[i]));
    or2  u_mux  (.a(ld_v[i]),   .b(cnt_v[i]),   .y(mux[i]));
    and2 u_rst  (.a(rst_n),     .b(mux[i]),     .y(d[i]));
    dff  u_ff   (.clk(clk),     .d(d[i]),       .q(q[i]));
  end

  and2 u_tc (.a(tgl[WIDTH]), .b(ld_n), .y(bus.tc));

  assign bus.q = q;
endmodule

// File: tb/tb_cnt_updown_ff.sv
// Bench for cnt_updown_ff: directed vector table, WIDTH=4 corner sequences,
// and random stimulus against an arithmetic reference model.
module tb_cnt_updown_ff;
  logic clk = 1'b0;
  logic rst8, rst4;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cnt_updown_ff_if #(.WIDTH(8)) bus8 ();
  cnt_updown_ff_if #(.WIDTH(4)) bus4 ();

  cnt_updown_ff #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));
  cnt_updown_ff #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));

  typedef struct {
    bit       rst, ld, en, up;
    bit [7:0] din;
    bit [7:0] exp_q;
    bit       chk_tc;
    bit       exp_tc;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive controls after the falling edge, check TC before the rising edge, Q after it.
  task automatic step8(input vec_t v, input string nm);
    @(negedge clk);
    rst8 = v.rst; bus8.ld = v.ld; bus8.en = v.en; bus8.up = v.up; bus8.din = v.din;
    #1;
    if (v.chk_tc) check({nm, " tc"}, int'(bus8.tc), int'(v.exp_tc));
    @(posedge clk);
    #1;
    check({nm, " q"}, int'(bus8.q), int'(v.exp_q));
  endtask

  task automatic step4(input bit r, input bit l, input bit e, input bit u,
                       input bit [3:0] dv, output bit tc_seen);
    @(negedge clk);
    rst4 = r; bus4.ld = l; bus4.en = e; bus4.up = u; bus4.din = dv;
    #1;
    tc_seen = bus4.tc;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next(int q, bit r, bit l, bit e, bit u, int dv, int w);
    int m = (1 << w) - 1;
    if (r) return 0;
    if (l) return dv & m;
    if (e) return u ? ((q + 1) & m) : ((q + m) & m);
    return q;
  endfunction

  function automatic bit model_tc(int q, bit l, bit e, bit u, int w);
    int m = (1 << w) - 1;
    return e && !l && ((u && q == m) || (!u && q == 0));
  endfunction

  vec_t vt[$];

  initial begin
    bit tc4;
    int tc_cnt, exp4, q8;
    rst8 = 1'b0; bus8.ld = 1'b0; bus8.en = 1'b0; bus8.up = 1'b0; bus8.din = '0;
    rst4 = 1'b0; bus4.ld = 1'b0; bus4.en = 1'b0; bus4.up = 1'b0; bus4.din = '0;

    //        rst ld en up din    q      chk tc
    vt.push_back('{1, 0, 0, 0, 8'h00, 8'h00, 0, 0});
    vt.push_back('{1, 1, 1, 1, 8'h5A, 8'h00, 1, 0});
    vt.push_back('{1, 0, 1, 0, 8'h00, 8'h00, 1, 1});
    vt.push_back('{0, 1, 0, 0, 8'hFD, 8'hFD, 1, 0});
    vt.push_back('{0, 0, 1, 1, 8'h00, 8'hFE, 1, 0});
    vt.push_back('{0, 0, 1, 1, 8'h00, 8'hFF, 1, 0});
    vt.push_back('{0, 0, 1, 1, 8'h00, 8'h00, 1, 1});
    vt.push_back('{0, 0, 1, 1, 8'h00, 8'h01, 1, 0});
    vt.push_back('{0, 1, 0, 0, 8'h02, 8'h02, 1, 0});
    vt.push_back('{0, 0, 1, 0, 8'h00, 8'h01, 1, 0});
    vt.push_back('{0, 0, 1, 0, 8'h00, 8'h00, 1, 0});
    vt.push_back('{0, 0, 1, 0, 8'h00, 8'hFF, 1, 1});
    vt.push_back('{0, 0, 1, 0, 8'h00, 8'hFE, 1, 0});
    vt.push_back('{0, 1, 0, 0, 8'h10, 8'h10, 1, 0});
    vt.push_back('{0, 1, 1, 1, 8'h80, 8'h80, 1, 0});
    vt.push_back('{1, 1, 0, 0, 8'h33, 8'h00, 1, 0});
    vt.push_back('{0, 1, 0, 0, 8'h7F, 8'h7F, 1, 0});
    vt.push_back('{0, 0, 0, 1, 8'h00, 8'h7F, 1, 0});
    vt.push_back('{0, 0, 0, 0, 8'hAA, 8'h7F, 1, 0});
    vt.push_back('{0, 0, 0, 1, 8'h00, 8'h7F, 1, 0});
    vt.push_back('{0, 0, 1, 1, 8'h00, 8'h80, 1, 0});
    vt.push_back('{0, 0, 1, 0, 8'h00, 8'h7F, 1, 0});

    for (int i = 0; i < vt.size(); i++) step8(vt[i], $sformatf("vec%0d", i));

    // WIDTH=4: count to 0xB, reset mid-count, resume
    step4(1, 0, 0, 0, 4'h0, tc4);
    check("w4 reset", int'(bus4.q), 0);
    for (int i = 1; i <= 11; i++) step4(0, 0, 1, 1, 4'h0, tc4);
    check("w4 up to B", int'(bus4.q), 4'hB);
    step4(1, 0, 1, 1, 4'h0, tc4);
    check("w4 mid reset", int'(bus4.q), 0);
    step4(0, 0, 1, 1, 4'h0, tc4);
    check("w4 first after reset", int'(bus4.q), 1);

    // Full 16-edge sweep: one wrap, TC high exactly once
    tc_cnt = 0;
    exp4 = 1;
    for (int i = 0; i < 16; i++) begin
      step4(0, 0, 1, 1, 4'h0, tc4);
      if (tc4) tc_cnt++;
      exp4 = (exp4 + 1) % 16;
      check($sformatf("w4 sweep%0d", i), int'(bus4.q), exp4);
    end
    check("w4 sweep tc count", tc_cnt, 1);

    // Random stimulus vs arithmetic model; start from a known reset
    q8 = 0;
    begin
      vec_t v;
      v = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0};
      step8(v, "rnd reset");
    end
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v.rst = ($urandom_range(0, 19) == 0);
      v.ld  = ($urandom_range(0, 7) == 0);
      v.en  = ($urandom_range(0, 3) != 0);
      v.up  = $urandom_range(0, 1);
      // bias loads toward the wrap boundaries
      case ($urandom_range(0, 3))
        0:       v.din = 8'hFF;
        1:       v.din = 8'h00;
        default: v.din = 8'($urandom_range(0, 255));
      endcase
      v.chk_tc = 1'b1;
      v.exp_tc = model_tc(q8, v.ld, v.en, v.up, 8);
      q8 = model_next(q8, v.rst, v.ld, v.en, v.up, int'(v.din), 8);
      v.exp_q = 8'(q8);
      step8(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
